// File: rtl/inst_encoder_if.sv
// Handshake and issue bundle between producer, inst_encoder and instruction register.
// The consumer-side signals (halt, inst, inst_valid) share the bundle with the producer side.
interface inst_encoder_if #(
  parameter int unsigned DEPTH = 4
) ();
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [2:0]    ALU_Sel;
  logic [7:0]    A;
  logic          halt;
  logic [10:0]   inst;
  logic          inst_valid;
  logic [CW-1:0] count;
  logic [1:0]    state;

  modport master (
    output in_valid, ALU_Sel, A, halt,
    input  in_ready, inst, inst_valid, count, state
  );

  modport slave (
    input  in_valid, ALU_Sel, A, halt,
    output in_ready, inst, inst_valid, count, state
  );
endinterface

// File: rtl/inst_encoder.sv
// Packs {A, ALU_Sel} into 11-bit instruction words, buffers them in a DEPTH-entry FIFO
// and issues one word per cycle to the instruction register unless the consumer halts.
module inst_encoder #(
  parameter int unsigned DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  inst_encoder_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned IW = 11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          in_ready_q, in_ready_d;
  logic [IW-1:0] inst_q, inst_d;
  logic          inst_valid_q, inst_valid_d;
  logic          push;
  logic          pop;

  // in_ready comes from a register, so halt never reaches it combinationally.
  always_comb begin
    push = bus.in_valid && in_ready_q;
    pop  = (state_q == RUN) && !bus.halt && (count_q != '0);
  end

  // Next-state for pointers, occupancy, issue register and FSM.
  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    inst_d       = inst_q;
    inst_valid_d = 1'b0;

    if (push) begin
      wptr_d = wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d       = rptr_q + PW'(1);
      inst_d       = mem_q[rptr_q];
      inst_valid_d = 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    in_ready_d = (count_d != CW'(DEPTH));

    if (bus.halt) begin
      state_d = HALTED;
    end else begin
      case (state_q)
        HALTED:  state_d = (count_q != '0) ? RUN : IDLE;
        IDLE:    if (count_q != '0) state_d = RUN;
        RUN:     if ((count_q == CW'(1)) && pop && !push) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      in_ready_q   <= 1'b1;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      in_ready_q   <= in_ready_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  // Storage is unreset; a write during reset lands behind the cleared pointers and is never read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= {bus.A, bus.ALU_Sel};
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.inst       = inst_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.count      = count_q;
  assign bus.state      = state_q;
endmodule

// File: tb/tb_inst_encoder.sv
// Directed self-checking bench for inst_encoder with DEPTH=4.
module tb_inst_encoder;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  inst_encoder_if #(.DEPTH(DEPTH)) bus ();

  inst_encoder #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [2:0] s);
    bus.in_valid = v;
    bus.A        = a;
    bus.ALU_Sel  = s;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.halt = 1'b0;
    drive(1'b0, 8'h00, 3'd0);
    tick();
    rst = 1'b0;
    total++; if (bus.inst !== 11'h000) begin bad++; $display("FAIL reset_inst got=%h exp=000", bus.inst); end
    total++; if (bus.inst_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.inst_valid); end
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    total++; if (bus.state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_single();
    drive(1'b1, 8'hA5, 3'b011);
    tick();
    drive(1'b0, 8'h00, 3'd0);
    total++; if (bus.count !== 3'd1 || bus.state !== 2'd0 || bus.inst_valid !== 1'b0) begin
      bad++; $display("FAIL single_push count=%0d state=%0d valid=%b exp 1/0/0", bus.count, bus.state, bus.inst_valid); end
    tick();
    total++; if (bus.state !== 2'd1 || bus.inst_valid !== 1'b0) begin
      bad++; $display("FAIL single_run state=%0d valid=%b exp 1/0", bus.state, bus.inst_valid); end
    tick();
    total++; if (bus.inst_valid !== 1'b1 || bus.inst !== 11'h52B) begin
      bad++; $display("FAIL single_issue valid=%b inst=%h exp 1/52B", bus.inst_valid, bus.inst); end
    total++; if (bus.count !== 3'd0 || bus.state !== 2'd0) begin
      bad++; $display("FAIL single_idle count=%0d state=%0d exp 0/0", bus.count, bus.state); end
    tick();
    total++; if (bus.inst_valid !== 1'b0 || bus.inst !== 11'h52B) begin
      bad++; $display("FAIL single_hold valid=%b inst=%h exp 0/52B", bus.inst_valid, bus.inst); end
  endtask

  task automatic test_fill_halt();
    logic [10:0] w [4];
    bus.halt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'h10 + 8'(i), 3'(i));
      if (i < 4) w[i] = {8'h10 + 8'(i), 3'(i)};
      tick();
      total++; if (bus.state !== 2'd2 || bus.count !== 3'((i < 4) ? i + 1 : 4) || bus.in_ready !== ((i + 1) < 4)) begin
        bad++; $display("FAIL fill_step%0d state=%0d count=%0d ready=%b", i, bus.state, bus.count, bus.in_ready); end
    end
    drive(1'b0, 8'h00, 3'd0);
    bus.halt = 1'b0;
    tick();
    total++; if (bus.state !== 2'd1 || bus.count !== 3'd4 || bus.inst_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL fill_release state=%0d count=%0d valid=%b ready=%b exp 1/4/0/0", bus.state, bus.count, bus.inst_valid, bus.in_ready); end
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if (bus.inst_valid !== 1'b1 || bus.inst !== w[k]) begin
        bad++; $display("FAIL fill_order%0d valid=%b inst=%h exp 1/%h", k, bus.inst_valid, bus.inst, w[k]); end
      if (k == 0) begin
        total++; if (bus.count !== 3'd3 || bus.in_ready !== 1'b1) begin
          bad++; $display("FAIL full_pop count=%0d ready=%b exp 3/1", bus.count, bus.in_ready); end
      end
    end
    total++; if (bus.count !== 3'd0 || bus.state !== 2'd0) begin
      bad++; $display("FAIL fill_drained count=%0d state=%0d exp 0/0", bus.count, bus.state); end
    tick();
    total++; if (bus.inst_valid !== 1'b0) begin bad++; $display("FAIL fill_quiet valid=%b exp 0", bus.inst_valid); end
  endtask

  task automatic test_streaming();
    logic [10:0] w [12];
    for (int i = 0; i < 12; i++) begin
      w[i] = {8'h30 + 8'(i), 3'(i)};
      drive(1'b1, 8'h30 + 8'(i), 3'(i));
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready%0d got=%b exp=1", i, bus.in_ready); end
      tick();
      total++; if (bus.count !== 3'((i == 0) ? 1 : 2)) begin
        bad++; $display("FAIL stream_count%0d got=%0d exp=%0d", i, bus.count, (i == 0) ? 1 : 2); end
      if (i >= 2) begin
        total++; if (bus.inst_valid !== 1'b1 || bus.inst !== w[i-2]) begin
          bad++; $display("FAIL stream_issue%0d valid=%b inst=%h exp 1/%h", i, bus.inst_valid, bus.inst, w[i-2]); end
      end
    end
    drive(1'b0, 8'h00, 3'd0);
    for (int k = 10; k < 12; k++) begin
      tick();
      total++; if (bus.inst_valid !== 1'b1 || bus.inst !== w[k]) begin
        bad++; $display("FAIL stream_tail%0d valid=%b inst=%h exp 1/%h", k, bus.inst_valid, bus.inst, w[k]); end
    end
    total++; if (bus.count !== 3'd0 || bus.state !== 2'd0) begin
      bad++; $display("FAIL stream_end count=%0d state=%0d exp 0/0", bus.count, bus.state); end
    tick();
    total++; if (bus.inst_valid !== 1'b0) begin bad++; $display("FAIL stream_quiet valid=%b exp 0", bus.inst_valid); end
  endtask

  task automatic test_halt_pulse();
    logic [10:0] w [6];
    for (int i = 0; i < 6; i++) w[i] = {8'hC0 + 8'(i), 3'(5 - i)};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'hC0 + 8'(i), 3'(5 - i));
      tick();
      if (i >= 2) begin
        total++; if (bus.inst_valid !== 1'b1 || bus.inst !== w[i-2]) begin
          bad++; $display("FAIL pulse_pre%0d valid=%b inst=%h exp 1/%h", i, bus.inst_valid, bus.inst, w[i-2]); end
      end
    end
    bus.halt = 1'b1;
    drive(1'b1, 8'hC5, 3'd0);
    tick();
    drive(1'b0, 8'h00, 3'd0);
    total++; if (bus.inst_valid !== 1'b0 || bus.count !== 3'd3 || bus.state !== 2'd2) begin
      bad++; $display("FAIL pulse_h1 valid=%b count=%0d state=%0d exp 0/3/2", bus.inst_valid, bus.count, bus.state); end
    tick();
    total++; if (bus.inst_valid !== 1'b0 || bus.count !== 3'd3 || bus.inst !== w[2]) begin
      bad++; $display("FAIL pulse_h2 valid=%b count=%0d inst=%h exp 0/3/%h", bus.inst_valid, bus.count, bus.inst, w[2]); end
    bus.halt = 1'b0;
    tick();
    total++; if (bus.inst_valid !== 1'b0 || bus.state !== 2'd1) begin
      bad++; $display("FAIL pulse_resume valid=%b state=%0d exp 0/1", bus.inst_valid, bus.state); end
    for (int k = 3; k < 6; k++) begin
      tick();
      total++; if (bus.inst_valid !== 1'b1 || bus.inst !== w[k]) begin
        bad++; $display("FAIL pulse_order%0d valid=%b inst=%h exp 1/%h", k, bus.inst_valid, bus.inst, w[k]); end
    end
    total++; if (bus.count !== 3'd0 || bus.state !== 2'd0) begin
      bad++; $display("FAIL pulse_end count=%0d state=%0d exp 0/0", bus.count, bus.state); end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.halt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'hE0 + 8'(i), 3'(i));
      tick();
    end
    total++; if (bus.count !== 3'd3 || bus.state !== 2'd2) begin
      bad++; $display("FAIL rmid_setup count=%0d state=%0d exp 3/2", bus.count, bus.state); end
    rst = 1'b1;
    bus.halt = 1'b0;
    drive(1'b1, 8'hFF, 3'd7);
    tick();
    rst = 1'b0;
    drive(1'b0, 8'h00, 3'd0);
    total++; if (bus.count !== 3'd0 || bus.inst !== 11'h000 || bus.inst_valid !== 1'b0 || bus.state !== 2'd0 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL rmid_reset count=%0d inst=%h valid=%b state=%0d ready=%b exp 0/000/0/0/1",
                      bus.count, bus.inst, bus.inst_valid, bus.state, bus.in_ready); end
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if (bus.inst_valid !== 1'b0 || bus.count !== 3'd0) begin
        bad++; $display("FAIL rmid_stale%0d valid=%b count=%0d exp 0/0", k, bus.inst_valid, bus.count); end
    end
    drive(1'b1, 8'h5A, 3'd2);
    tick();
    drive(1'b0, 8'h00, 3'd0);
    tick();
    tick();
    total++; if (bus.inst_valid !== 1'b1 || bus.inst !== 11'h2D2) begin
      bad++; $display("FAIL rmid_fresh valid=%b inst=%h exp 1/2D2", bus.inst_valid, bus.inst); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_halt();
    test_streaming();
    test_halt_pulse();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
